// File: rtl/main_decoder.sv
// LEGv8 main control decoder: maps Op = instr[31:21] to datapath strobes, ALU-op class and exception cause.
// Define MAINDEC_OUTREG_EN to register every output on posedge clk (1-cycle latency); otherwise purely combinational.
module main_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  output logic        Reg2Loc,
  output logic [1:0]  ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic        ERet,
  output logic [3:0]  EStatus
);

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ERET = 11'b11010110100;
  localparam logic [10:0] OP_MRS  = 11'b11010101001;

  typedef struct packed {
    logic       reg2loc;
    logic [1:0] alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       eret;
    logic [1:0] aluop;
    logic [3:0] estatus;
  } ctrl_t;

  ctrl_t ctrl_d;
  ctrl_t ctrl_out;

  // Start from the invalid-opcode encoding so any unmatched or unknown Op
  // raises EStatus 0010 with every side-effecting strobe held low.
  always_comb begin
    ctrl_d         = '0;
    ctrl_d.estatus = 4'b0010;
    case (Op)
      OP_LDUR: begin
        ctrl_d.alusrc   = 2'b01;
        ctrl_d.memtoreg = 1'b1;
        ctrl_d.regwrite = 1'b1;
        ctrl_d.memread  = 1'b1;
        ctrl_d.aluop    = 2'b00;
        ctrl_d.estatus  = 4'b0000;
      end
      OP_STUR: begin
        ctrl_d.reg2loc  = 1'b1;
        ctrl_d.alusrc   = 2'b01;
        ctrl_d.memwrite = 1'b1;
        ctrl_d.aluop    = 2'b00;
        ctrl_d.estatus  = 4'b0000;
      end
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.aluop    = 2'b10;
        ctrl_d.estatus  = 4'b0000;
      end
      OP_ERET: begin
        ctrl_d.branch  = 1'b1;
        ctrl_d.eret    = 1'b1;
        ctrl_d.aluop   = 2'b01;
        ctrl_d.estatus = 4'b0000;
      end
      OP_MRS: begin
        ctrl_d.reg2loc  = 1'b1;
        ctrl_d.alusrc   = 2'b10;
        ctrl_d.regwrite = 1'b1;
        ctrl_d.aluop    = 2'b01;
        ctrl_d.estatus  = 4'b0000;
      end
      default: begin
        // CBZ ignores the low three opcode bits; an unknown prefix falls to invalid.
        if (Op[10:3] == OP_CBZ) begin
          ctrl_d.reg2loc = 1'b1;
          ctrl_d.branch  = 1'b1;
          ctrl_d.aluop   = 2'b01;
          ctrl_d.estatus = 4'b0000;
        end
      end
    endcase
  end

`ifdef MAINDEC_OUTREG_EN
  ctrl_t ctrl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ctrl_out = ctrl_q;
`else
  logic unused_clk;
  assign unused_clk = clk;
  assign ctrl_out   = reset ? '0 : ctrl_d;
`endif

  assign Reg2Loc  = ctrl_out.reg2loc;
  assign ALUSrc   = ctrl_out.alusrc;
  assign MemtoReg = ctrl_out.memtoreg;
  assign RegWrite = ctrl_out.regwrite;
  assign MemRead  = ctrl_out.memread;
  assign MemWrite = ctrl_out.memwrite;
  assign Branch   = ctrl_out.branch;
  assign ERet     = ctrl_out.eret;
  assign ALUOp    = ctrl_out.aluop;
  assign EStatus  = ctrl_out.estatus;

endmodule

// File: tb/tb_main_decoder.sv
// Directed self-checking bench for main_decoder; expected control words are hand-encoded in the order
// {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ERet, ALUOp, EStatus}.
module tb_main_decoder;

  logic        clk;
  logic        reset;
  logic [10:0] Op;
  logic        Reg2Loc;
  logic [1:0]  ALUSrc;
  logic        MemtoReg;
  logic        RegWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic [1:0]  ALUOp;
  logic        ERet;
  logic [3:0]  EStatus;

  int checks;
  int failures;

  logic [14:0] obs;
  assign obs = {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
                Branch, ERet, ALUOp, EStatus};

  localparam logic [14:0] EXP_ZERO  = 15'b0_00_0_0_0_0_0_0_00_0000;
  localparam logic [14:0] EXP_LDUR  = 15'b0_01_1_1_1_0_0_0_00_0000;
  localparam logic [14:0] EXP_STUR  = 15'b1_01_0_0_0_1_0_0_00_0000;
  localparam logic [14:0] EXP_CBZ   = 15'b1_00_0_0_0_0_1_0_01_0000;
  localparam logic [14:0] EXP_RTYPE = 15'b0_00_0_1_0_0_0_0_10_0000;
  localparam logic [14:0] EXP_ERET  = 15'b0_00_0_0_0_0_1_1_01_0000;
  localparam logic [14:0] EXP_MRS   = 15'b1_10_0_1_0_0_0_0_01_0000;
  localparam logic [14:0] EXP_INVAL = 15'b0_00_0_0_0_0_0_0_00_0010;

  main_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .Op       (Op),
    .Reg2Loc  (Reg2Loc),
    .ALUSrc   (ALUSrc),
    .MemtoReg (MemtoReg),
    .RegWrite (RegWrite),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Branch   (Branch),
    .ALUOp    (ALUOp),
    .ERet     (ERet),
    .EStatus  (EStatus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: change Op away from the edge, then wait until the result is
  // visible (one rising edge when the outputs are registered).
  task automatic apply_op(input logic [10:0] op);
    @(negedge clk);
    Op = op;
`ifdef MAINDEC_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Op    = 11'b11111000010;
    #1;
    checks++;
    if (obs !== EXP_ZERO) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", obs, EXP_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mem();
    apply_op(11'b11111000010);
    checks++;
    if (obs !== EXP_LDUR) begin
      failures++;
      $display("FAIL ldur got=%b want=%b", obs, EXP_LDUR);
    end
    apply_op(11'b11111000000);
    checks++;
    if (obs !== EXP_STUR) begin
      failures++;
      $display("FAIL stur got=%b want=%b", obs, EXP_STUR);
    end
  endtask

  task automatic test_cbz();
    logic [10:0] ops [2];
    ops[0] = 11'b10110100000;
    ops[1] = 11'b10110100111;
    for (int i = 0; i < 2; i++) begin
      apply_op(ops[i]);
      checks++;
      if (obs !== EXP_CBZ) begin
        failures++;
        $display("FAIL cbz op=%b got=%b want=%b", ops[i], obs, EXP_CBZ);
      end
    end
  endtask

  task automatic test_rtype();
    logic [10:0] ops [4];
    ops[0] = 11'b10001011000;
    ops[1] = 11'b11001011000;
    ops[2] = 11'b10001010000;
    ops[3] = 11'b10101010000;
    for (int i = 0; i < 4; i++) begin
      apply_op(ops[i]);
      checks++;
      if (obs !== EXP_RTYPE) begin
        failures++;
        $display("FAIL rtype op=%b got=%b want=%b", ops[i], obs, EXP_RTYPE);
      end
    end
  endtask

  task automatic test_system();
    apply_op(11'b11010110100);
    checks++;
    if (obs !== EXP_ERET) begin
      failures++;
      $display("FAIL eret got=%b want=%b", obs, EXP_ERET);
    end
    apply_op(11'b11010101001);
    checks++;
    if (obs !== EXP_MRS) begin
      failures++;
      $display("FAIL mrs got=%b want=%b", obs, EXP_MRS);
    end
  endtask

  // Invalid opcodes, including single-bit neighbours of valid encodings.
  task automatic test_invalid();
    logic [10:0] ops [5];
    ops[0] = 11'b00000000000;
    ops[1] = 11'b11111000011;
    ops[2] = 11'b10110101000;
    ops[3] = 11'b10001011001;
    ops[4] = 11'b11010110101;
    for (int i = 0; i < 5; i++) begin
      apply_op(ops[i]);
      checks++;
      if (obs !== EXP_INVAL) begin
        failures++;
        $display("FAIL invalid op=%b got=%b want=%b", ops[i], obs, EXP_INVAL);
      end
    end
  endtask

  // Reset must clear outputs immediately, without waiting for a clock edge.
  task automatic test_reset_override();
    apply_op(11'b11111000010);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== EXP_ZERO) begin
      failures++;
      $display("FAIL reset_override got=%b want=%b", obs, EXP_ZERO);
    end
    @(negedge clk);
    reset = 1'b0;
    apply_op(11'b11111000000);
    checks++;
    if (obs !== EXP_STUR) begin
      failures++;
      $display("FAIL after_reset got=%b want=%b", obs, EXP_STUR);
    end
  endtask

  // Back-to-back opcode changes, each checked on its own cycle.
  task automatic test_back_to_back();
    apply_op(11'b10110100011);
    checks++;
    if (obs !== EXP_CBZ) begin
      failures++;
      $display("FAIL b2b_cbz got=%b want=%b", obs, EXP_CBZ);
    end
    apply_op(11'b11010101001);
    checks++;
    if (obs !== EXP_MRS) begin
      failures++;
      $display("FAIL b2b_mrs got=%b want=%b", obs, EXP_MRS);
    end
    apply_op(11'b01111111111);
    checks++;
    if (obs !== EXP_INVAL) begin
      failures++;
      $display("FAIL b2b_invalid got=%b want=%b", obs, EXP_INVAL);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    Op       = '0;
    test_reset();
    test_mem();
    test_cbz();
    test_rtype();
    test_system();
    test_invalid();
    test_reset_override();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
